// File: rtl/tj_readout_rx_pkg.sv
// ---------------------------------------------------------------------------
// tj_readout_rx_pkg
//
// Purpose : Shared types and constants for the chip readout receiver
//           (tj_readout_rx) and its output FIFO.
//
// Contents:
//   WORD_W, COL_W, DATA_W  serial word geometry {ColAddr, ColData}, MSB first
//   TS_W                   width of the optional hit timestamp
//   rx_state_t             receiver FSM states
//   rx_word_t              one buffered hit word as stored in the FIFO
//
// Configuration macro: TJ_READOUT_RX_TIMESTAMP_EN adds the ts field to
// rx_word_t. Without it the stored word is exactly WORD_W bits wide.
// ---------------------------------------------------------------------------
package tj_readout_rx_pkg;

  localparam int WORD_W = 27;
  localparam int COL_W  = 6;
  localparam int DATA_W = 21;
  localparam int TS_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SHIFT,
    PUSH
  } rx_state_t;

  typedef struct packed {
    logic [COL_W-1:0]  col;
    logic [DATA_W-1:0] data;
`ifdef TJ_READOUT_RX_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
  } rx_word_t;

endpackage

// File: rtl/tj_readout_rx_fifo.sv
// ---------------------------------------------------------------------------
// tj_rx_fifo
//
// Purpose : Synchronous first-word-fall-through FIFO shared by the DAQ
//           receivers. The head entry is visible on o_rdata whenever
//           o_empty is low; o_rdata reads as zero while the FIFO is empty.
//           Push and pop in the same cycle are accepted at any occupancy
//           (a push into a full FIFO succeeds only when a pop frees a slot
//           in the same cycle).
//
// Parameters:
//   WIDTH  entry width in bits
//   DEPTH  entry count, power of two, at least 2
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_push   in   write i_wdata this cycle
//   i_wdata  in   WIDTH  write data
//   i_pop    in   consume the head this cycle (ignored when empty)
//   o_rdata  out  WIDTH  head entry
//   o_full   out  registered, FIFO holds DEPTH entries
//   o_empty  out  registered, FIFO holds no entries
//   o_free   out  number of free slots
// ---------------------------------------------------------------------------
module tj_rx_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_free
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_countNext;
  logic             r_full;
  logic             r_empty;
  logic             w_doPush;
  logic             w_doPop;

  // A pop on an empty FIFO is meaningless; a push into a full FIFO is only
  // legal when the same-cycle pop makes room for it.
  assign w_doPop  = i_pop & ~r_empty;
  assign w_doPush = i_push & (~r_full | w_doPop);

  // Occupancy after this cycle's push/pop, used so that full/empty are
  // registered yet already reflect the current cycle's traffic.
  always_comb begin
    w_countNext = r_count;
    if (w_doPush && !w_doPop) begin
      w_countNext = r_count + CNT_W'(1);
    end else if (!w_doPush && w_doPop) begin
      w_countNext = r_count - CNT_W'(1);
    end
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      r_count <= w_countNext;
      r_full  <= (w_countNext == CNT_W'(DEPTH));
      r_empty <= (w_countNext == '0);
    end
  end

  // Storage is not reset; stale contents are hidden by the empty gating on
  // the read port below.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  assign o_rdata = r_empty ? '0 : r_mem[r_rdPtr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_free  = CNT_W'(DEPTH) - r_count;

endmodule

// File: rtl/tj_readout_rx.sv
// ---------------------------------------------------------------------------
// tj_readout_rx
//
// Purpose : FPGA-side receiver for the chip readout serializer. Watches the
//           chip TokenOut, issues one Read strobe per hit word, deserializes
//           the 27-bit word {ColAddr[5:0], ColData[20:0]} (MSB first) from
//           DataIn, buffers it in a FWFT FIFO and offers it to the DAQ on a
//           valid/ready interface. A FIFO slot is reserved before each Read,
//           so readout stalls instead of losing hits when the FIFO fills.
//
// Parameters:
//   READ_LAT    cycles of WAIT between the Read cycle and the first SHIFT
//               cycle, 1..7
//   FIFO_DEPTH  output FIFO capacity, power of two, at least 2
//
// Ports:
//   ClkOut     in   serial clock, all logic on its rising edge
//   ResetB     in   asynchronous active-low reset (released synchronously)
//   TokenIn    in   chip TokenOut, high while hits are pending
//   DataIn     in   chip serial DataOut
//   Read       out  one-cycle read strobe per word
//   Busy       out  high while a word is in flight (FSM not IDLE)
//   WordValid  out  FIFO head valid
//   WordReady  in   consumer accepts the head when WordValid is high
//   WordCol    out  6   column address of the head word
//   WordData   out  21  column data of the head word
//   FifoFull   out  FIFO holds FIFO_DEPTH words
//   WordTs     out  16  head word timestamp (only with the macro below)
//
// Configuration macro: TJ_READOUT_RX_TIMESTAMP_EN adds a free-running 16-bit
// ClkOut counter, latched in the READ cycle and stored with each word.
// ---------------------------------------------------------------------------
module tj_readout_rx
  import tj_readout_rx_pkg::*;
#(
  parameter int READ_LAT   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              ClkOut,
  input  logic              ResetB,
  input  logic              TokenIn,
  input  logic              DataIn,
  output logic              Read,
  output logic              Busy,
  output logic              WordValid,
  input  logic              WordReady,
  output logic [COL_W-1:0]  WordCol,
  output logic [DATA_W-1:0] WordData,
  output logic              FifoFull
`ifdef TJ_READOUT_RX_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]   WordTs
`endif
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int FIFO_W = $bits(rx_word_t);

  logic [1:0]        r_rstSync;
  logic              w_rstN;

  rx_state_t         r_state;
  logic [2:0]        r_lat;
  logic [4:0]        r_bitCnt;
  logic [WORD_W-1:0] r_shift;
  logic              r_read;
  logic              r_busy;

  logic              w_fifoPush;
  logic              w_fifoPop;
  logic              w_fifoFull;
  logic              w_fifoEmpty;
  logic [CNT_W-1:0]  w_fifoFree;
  logic [CNT_W:0]    w_freeAfterPop;
  rx_word_t          w_wrWord;
  rx_word_t          w_rdWord;

`ifdef TJ_READOUT_RX_TIMESTAMP_EN
  logic [TS_W-1:0]   r_tsCnt;
  logic [TS_W-1:0]   r_tsLatch;
`endif

  // Reset synchronizer: assertion reaches every register at once through
  // the async clear, release is aligned to ClkOut two edges later.
  always_ff @(posedge ClkOut or negedge ResetB) begin
    if (!ResetB) begin
      r_rstSync <= 2'b00;
    end else begin
      r_rstSync <= {r_rstSync[0], 1'b1};
    end
  end

  assign w_rstN = r_rstSync[1];

  assign w_fifoPop  = ~w_fifoEmpty & WordReady;
  assign w_fifoPush = (r_state == PUSH);

  // Free slots once this cycle's pop is accounted for. In IDLE nothing is
  // in flight, so one slot is enough to start a read. In PUSH the word being
  // written still occupies a slot, so a follow-on read needs two.
  assign w_freeAfterPop = {1'b0, w_fifoFree} + {{CNT_W{1'b0}}, w_fifoPop};

  // Receiver FSM. Read and Busy are registered and change together with the
  // state so that they are glitch-free towards the chip.
  always_ff @(posedge ClkOut or negedge w_rstN) begin
    if (!w_rstN) begin
      r_state  <= IDLE;
      r_lat    <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_read   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_read <= 1'b0;
      case (r_state)
        IDLE: begin
          if (TokenIn && (w_freeAfterPop >= (CNT_W+1)'(1))) begin
            r_state <= READ;
            r_read  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        READ: begin
          r_state <= WAIT;
          r_lat   <= 3'(READ_LAT - 1);
        end
        WAIT: begin
          if (r_lat == '0) begin
            r_state  <= SHIFT;
            r_bitCnt <= '0;
          end else begin
            r_lat <= r_lat - 3'd1;
          end
        end
        SHIFT: begin
          r_shift <= {r_shift[WORD_W-2:0], DataIn};
          if (r_bitCnt == 5'(WORD_W - 1)) begin
            r_state <= PUSH;
          end else begin
            r_bitCnt <= r_bitCnt + 5'd1;
          end
        end
        PUSH: begin
          if (TokenIn && (w_freeAfterPop >= (CNT_W+1)'(2))) begin
            r_state <= READ;
            r_read  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TJ_READOUT_RX_TIMESTAMP_EN
  // Free-running timestamp; its value during the READ cycle tags the word.
  always_ff @(posedge ClkOut or negedge w_rstN) begin
    if (!w_rstN) begin
      r_tsCnt   <= '0;
      r_tsLatch <= '0;
    end else begin
      r_tsCnt <= r_tsCnt + TS_W'(1);
      if (r_state == READ) begin
        r_tsLatch <= r_tsCnt;
      end
    end
  end
`endif

  // Split the completed shift register into the stored word fields.
  always_comb begin
    w_wrWord      = '0;
    w_wrWord.col  = r_shift[WORD_W-1 -: COL_W];
    w_wrWord.data = r_shift[DATA_W-1:0];
`ifdef TJ_READOUT_RX_TIMESTAMP_EN
    w_wrWord.ts   = r_tsLatch;
`endif
  end

  tj_rx_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ClkOut),
    .rst_n   (w_rstN),
    .i_push  (w_fifoPush),
    .i_wdata (w_wrWord),
    .i_pop   (w_fifoPop),
    .o_rdata (w_rdWord),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty),
    .o_free  (w_fifoFree)
  );

  assign Read      = r_read;
  assign Busy      = r_busy;
  assign WordValid = ~w_fifoEmpty;
  assign WordCol   = w_rdWord.col;
  assign WordData  = w_rdWord.data;
  assign FifoFull  = w_fifoFull;
`ifdef TJ_READOUT_RX_TIMESTAMP_EN
  assign WordTs    = w_rdWord.ts;
`endif

endmodule

// File: tb/tb_tj_readout_rx.sv
// ---------------------------------------------------------------------------
// tb_tj_readout_rx
//
// Purpose : Self-checking bench for tj_readout_rx. A behavioural chip model
//           holds a queue of pending hits, raises TokenIn while the queue is
//           non-empty and serializes one hit per Read strobe. The expected
//           output stream is simply the order in which hits were handed to
//           the chip; a scoreboard compares every accepted word against it.
//           Table vectors check the field split with hand-computed values;
//           hand-written sequences cover burst spacing, backpressure, push
//           and pop in the same cycle, and reset mid-word.
//
// Configuration macro: TJ_READOUT_RX_TIMESTAMP_EN connects WordTs and checks
// the timestamp spacing of back-to-back words.
// ---------------------------------------------------------------------------
module tb_tj_readout_rx;

  localparam int L       = 2;
  localparam int DEPTH   = 8;
  localparam int WORD_CY = 1 + L + 27 + 1;

  logic        ClkOut    = 1'b0;
  logic        ResetB    = 1'b0;
  logic        TokenIn   = 1'b0;
  logic        DataIn    = 1'b0;
  logic        WordReady = 1'b0;
  logic        Read;
  logic        Busy;
  logic        WordValid;
  logic [5:0]  WordCol;
  logic [20:0] WordData;
  logic        FifoFull;
`ifdef TJ_READOUT_RX_TIMESTAMP_EN
  logic [15:0] WordTs;
  logic [15:0] tsQ[$];
`endif

  always #5 ClkOut = ~ClkOut;

  tj_readout_rx #(
    .READ_LAT   (L),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .ClkOut    (ClkOut),
    .ResetB    (ResetB),
    .TokenIn   (TokenIn),
    .DataIn    (DataIn),
    .Read      (Read),
    .Busy      (Busy),
    .WordValid (WordValid),
    .WordReady (WordReady),
    .WordCol   (WordCol),
    .WordData  (WordData),
    .FifoFull  (FifoFull)
`ifdef TJ_READOUT_RX_TIMESTAMP_EN
    ,
    .WordTs    (WordTs)
`endif
  );

  typedef struct {
    logic [26:0] word;
    logic [5:0]  expCol;
    logic [20:0] expData;
  } vec_t;

  vec_t        vecs[6];
  int          vecCount  = 0;
  int          missCount = 0;
  int          cyc       = 0;
  int          readCount = 0;
  int          readCycQ[$];
  logic [26:0] hitQ[$];
  logic [26:0] expQ[$];
  logic        active    = 1'b0;
  logic [26:0] curWord   = '0;
  int          startCyc  = 0;
  logic        prevHold  = 1'b0;
  logic [26:0] prevHead  = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeoutFail(input string name, input int budget);
    vecCount++;
    missCount++;
    $display("[TB] FAIL %s: condition not reached within %0d cycles", name, budget);
  endtask

  // Chip model and output scoreboard, both evaluated on the falling edge.
  always @(negedge ClkOut) begin
    cyc++;
    if (ResetB) begin
      if (prevHold) begin
        checkOutput("head_hold_valid", {31'd0, WordValid}, 32'd1);
        checkOutput("head_hold_word", {5'd0, WordCol, WordData}, {5'd0, prevHead});
      end
      if (WordValid && WordReady) begin
        if (expQ.size() == 0) begin
          vecCount++;
          missCount++;
          $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", {WordCol, WordData});
        end else begin
          checkOutput("word_order", {5'd0, WordCol, WordData}, {5'd0, expQ.pop_front()});
        end
`ifdef TJ_READOUT_RX_TIMESTAMP_EN
        tsQ.push_back(WordTs);
`endif
      end
      if (Read) begin
        readCount++;
        readCycQ.push_back(cyc);
        checkOutput("read_while_full", {31'd0, FifoFull}, 32'd0);
        checkOutput("read_with_hit_pending", {31'd0, hitQ.size() != 0}, 32'd1);
        if (hitQ.size() != 0) begin
          curWord  = hitQ.pop_front();
          active   = 1'b1;
          startCyc = cyc + L + 1;
        end
      end
      prevHold = WordValid && !WordReady;
      prevHead = {WordCol, WordData};
    end else begin
      active   = 1'b0;
      prevHold = 1'b0;
    end
    if (active && cyc >= startCyc && cyc < startCyc + 27) begin
      DataIn = curWord[26 - (cyc - startCyc)];
      if (cyc == startCyc + 26) active = 1'b0;
    end else begin
      DataIn = 1'($urandom_range(0, 1));
    end
    TokenIn = (hitQ.size() != 0);
  end

  task automatic addHit(input logic [26:0] w);
    hitQ.push_back(w);
    expQ.push_back(w);
  endtask

  task automatic waitValid(input int budget, input string name);
    int n = 0;
    while (!WordValid && n < budget) begin
      @(posedge ClkOut); #1;
      n++;
    end
    if (!WordValid) timeoutFail(name, budget);
  endtask

  task automatic waitReads(input int target, input int budget, input string name);
    int n = 0;
    while (readCount < target && n < budget) begin
      @(posedge ClkOut); #1;
      n++;
    end
    if (readCount < target) timeoutFail(name, budget);
  endtask

  task automatic waitDrain(input int budget, input string name);
    int n = 0;
    while ((hitQ.size() != 0 || expQ.size() != 0 || Busy || WordValid) && n < budget) begin
      @(posedge ClkOut); #1;
      n++;
    end
    if (n >= budget) timeoutFail(name, budget);
  endtask

  // Leaves the bench just after the rising edge that starts cycle 'target'.
  task automatic waitCycle(input int target);
    int n = 0;
    while (cyc < target - 1 && n < 2000) begin
      @(posedge ClkOut);
      n++;
    end
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_read"}, {31'd0, Read}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    checkOutput({tag, "_valid"}, {31'd0, WordValid}, 32'd0);
    checkOutput({tag, "_full"}, {31'd0, FifoFull}, 32'd0);
    checkOutput({tag, "_col"}, {26'd0, WordCol}, 32'd0);
    checkOutput({tag, "_data"}, {11'd0, WordData}, 32'd0);
`ifdef TJ_READOUT_RX_TIMESTAMP_EN
    checkOutput({tag, "_ts"}, {16'd0, WordTs}, 32'd0);
`endif
  endtask

  task automatic doReset();
    ResetB = 1'b0;
    hitQ.delete();
    expQ.delete();
    repeat (3) @(posedge ClkOut);
    #1;
    ResetB = 1'b1;
    repeat (4) @(posedge ClkOut);
    #1;
  endtask

  // One table vector: a single hit, held at the head, checked, then drained.
  task automatic applyStimulus(input vec_t v);
    int r0 = readCount;
    WordReady = 1'b0;
    addHit(v.word);
    waitValid(100, "table_valid");
    checkOutput("table_col", {26'd0, WordCol}, {26'd0, v.expCol});
    checkOutput("table_data", {11'd0, WordData}, {11'd0, v.expData});
    if (readCycQ.size() != 0)
      checkOutput("table_latency", 32'(cyc + 1 - readCycQ[$]), 32'(L + 29));
    repeat (3) @(posedge ClkOut);
    #1;
    checkOutput("table_reads", 32'(readCount - r0), 32'd1);
    checkOutput("table_busy", {31'd0, Busy}, 32'd0);
    WordReady = 1'b1;
    @(posedge ClkOut); #1;
    WordReady = 1'b0;
    checkOutput("table_drained", {31'd0, WordValid}, 32'd0);
  endtask

  initial begin
    int r0;
    int base;
    int n;

    vecs[0] = '{27'h5A12345, 6'h2D, 21'h012345};
    vecs[1] = '{27'h7FFFFFF, 6'h3F, 21'h1FFFFF};
    vecs[2] = '{27'h0000000, 6'h00, 21'h000000};
    vecs[3] = '{27'h4000000, 6'h20, 21'h000000};
    vecs[4] = '{27'h0000001, 6'h00, 21'h000001};
    vecs[5] = '{27'h2AAAAAA, 6'h15, 21'h0AAAAA};

    ResetB = 1'b0;
    repeat (3) @(posedge ClkOut);
    #1;
    checkResetOutputs("reset");
    ResetB = 1'b1;
    repeat (4) @(posedge ClkOut);
    #1;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Burst of five words with the consumer always ready.
    WordReady = 1'b1;
    r0   = readCount;
    base = readCycQ.size();
`ifdef TJ_READOUT_RX_TIMESTAMP_EN
    tsQ.delete();
`endif
    for (int i = 0; i < 5; i++) addHit({6'(i), 21'(i * 'h111)});
    waitDrain(400, "burst_drain");
    checkOutput("burst_reads", 32'(readCount - r0), 32'd5);
    for (int i = 1; i < 5; i++)
      if (readCycQ.size() > base + i)
        checkOutput("burst_spacing", 32'(readCycQ[base+i] - readCycQ[base+i-1]), 32'(WORD_CY));
`ifdef TJ_READOUT_RX_TIMESTAMP_EN
    for (int i = 1; i < 5; i++)
      if (tsQ.size() > i)
        checkOutput("burst_ts_step", {16'd0, 16'(tsQ[i] - tsQ[i-1])}, 32'(WORD_CY));
`endif

    // Backpressure: twelve hits, consumer stalled.
    WordReady = 1'b0;
    r0 = readCount;
    for (int i = 0; i < 12; i++) addHit(27'($urandom));
    waitReads(r0 + 8, 400, "bp_fill");
    repeat (WORD_CY + 10) @(posedge ClkOut);
    #1;
    checkOutput("bp_reads", 32'(readCount - r0), 32'd8);
    checkOutput("bp_full", {31'd0, FifoFull}, 32'd1);
    checkOutput("bp_valid", {31'd0, WordValid}, 32'd1);
    repeat (60) @(posedge ClkOut);
    #1;
    checkOutput("bp_stalled_reads", 32'(readCount - r0), 32'd8);
    checkOutput("bp_stalled_busy", {31'd0, Busy}, 32'd0);

    // Free one slot, then pop again in the PUSH cycle of the refill word.
    WordReady = 1'b1;
    @(posedge ClkOut); #1;
    WordReady = 1'b0;
    waitReads(r0 + 9, 20, "bp_refill_read");
    n = readCycQ[$];
    waitCycle(n + L + 28);
    WordReady = 1'b1;
    @(posedge ClkOut); #1;
    WordReady = 1'b0;
    waitReads(r0 + 10, 20, "bp_push_pop_read");
    checkOutput("bp_push_pop_spacing", 32'(readCycQ[$] - n), 32'(WORD_CY));
    repeat (WORD_CY + 10) @(posedge ClkOut);
    #1;
    checkOutput("bp_refull_reads", 32'(readCount - r0), 32'd10);
    checkOutput("bp_refull_full", {31'd0, FifoFull}, 32'd1);
    WordReady = 1'b1;
    waitDrain(400, "bp_drain");
    checkOutput("bp_total_reads", 32'(readCount - r0), 32'd12);

    // Reset while the tenth bit is being shifted in.
    addHit(27'h7FFFFFF);
    r0 = readCount;
    waitReads(r0 + 1, 20, "rst_shift_read");
    n = readCycQ[$];
    waitCycle(n + L + 1 + 10);
    #2;
    ResetB = 1'b0;
    #1;
    checkResetOutputs("rst_shift");
    doReset();
    applyStimulus(vecs[2]);

    // Reset while Read is high: the strobe must drop at once.
    WordReady = 1'b0;
    addHit(27'h1234567);
    n = 0;
    while (!Read && n < 20) begin
      @(posedge ClkOut); #1;
      n++;
    end
    if (!Read) timeoutFail("rst_read_wait", 20);
    ResetB = 1'b0;
    #1;
    checkOutput("rst_read_drop", {31'd0, Read}, 32'd0);
    checkOutput("rst_read_busy", {31'd0, Busy}, 32'd0);
    doReset();
    applyStimulus(vecs[0]);

    // Random traffic with a random consumer.
    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) addHit(27'($urandom));
      for (int c = 0; c < 3000 && (hitQ.size() != 0 || expQ.size() != 0 || Busy || WordValid); c++) begin
        WordReady = ($urandom_range(0, 3) != 0);
        @(posedge ClkOut); #1;
      end
      WordReady = 1'b1;
      waitDrain(100, "random_drain");
      WordReady = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vecCount, missCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
